// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite style word-organised memory slave.
// - Registered hrdata/hready/hresp; programmable wait states per data phase.
// - Illegal accesses (bad size, misaligned, out of range) get the two-cycle ERROR response.
// - Read data is fetched at the accept edge. A read that closes a write to the same
//   word gets the write's bytes forwarded.
// - Optional build macro AHB_SLV_ERR_CNT_EN adds a saturating 8-bit err_count output.
module ahb_slave_mem #(
    parameter int         DEPTH       = 256,
    parameter int         WAIT_STATES = 0,
    parameter logic [1:0] SEL_ID      = 2'd1
) (
    input  logic        clk,
    input  logic        hreset,
    input  logic [1:0]  hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hready,
    output logic        hresp
`ifdef AHB_SLV_ERR_CNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] WAIT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    // Byte-lane enables for a legal access, little-endian lane numbering.
    function automatic logic [3:0] lane_strb(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] strb;
        case (size)
            2'd0:    strb = 4'b0001 << lane;
            2'd1:    strb = lane[1] ? 4'b1100 : 4'b0011;
            2'd2:    strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
        return strb;
    endfunction

    // Replace the enabled byte lanes of old_word with those of new_word.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return res;
    endfunction

    logic [31:0]   mem_q [DEPTH];

    state_t        state_q;
    logic          hready_q;
    logic          hresp_q;
    logic [31:0]   hrdata_q;
    logic [2:0]    wait_cnt_q;
    logic          wr_q;
    logic [AW-1:0] idx_q;
    logic [3:0]    strb_q;
    logic [31:0]   rdbuf_q;
`ifdef AHB_SLV_ERR_CNT_EN
    logic [7:0]    err_cnt_q;
`endif

    logic          accept_s;
    logic          size_bad_s;
    logic          range_bad_s;
    logic          illegal_s;
    logic [AW-1:0] idx_s;
    logic [3:0]    strb_s;
    logic [31:0]   rd_fetch_s;
    logic          unused_ok_s;

    // hburst and htrans[0] carry no meaning for this slave.
    assign unused_ok_s = ^{hburst, htrans[0]};

    // Address-phase decode: accept, legality, lane enables and forwarded read data.
    always_comb begin
        accept_s    = hready_q && (hsel == SEL_ID) && htrans[1];
        idx_s       = haddr[AW+1:2];
        range_bad_s = |haddr[31:AW+2];
        case (hsize)
            3'd0:    size_bad_s = 1'b0;
            3'd1:    size_bad_s = haddr[0];
            3'd2:    size_bad_s = |haddr[1:0];
            default: size_bad_s = 1'b1;
        endcase
        illegal_s = size_bad_s | range_bad_s;
        strb_s    = lane_strb(hsize[1:0], haddr[1:0]);
        if ((state_q == ST_DATA) && wr_q && (idx_q == idx_s)) begin
            rd_fetch_s = merge_lanes(mem_q[idx_s], hwdata, strb_q);
        end else begin
            rd_fetch_s = mem_q[idx_s];
        end
    end

    // Commit write data at the closing edge of a write data phase; reset drops it.
    always_ff @(posedge clk) begin
        if (!hreset && (state_q == ST_DATA) && wr_q) begin
            mem_q[idx_q] <= merge_lanes(mem_q[idx_q], hwdata, strb_q);
        end
    end

    // Transfer FSM with registered bus responses.
    always_ff @(posedge clk) begin
        if (hreset) begin
            state_q    <= ST_IDLE;
            hready_q   <= 1'b1;
            hresp_q    <= 1'b0;
            hrdata_q   <= 32'd0;
            wait_cnt_q <= 3'd0;
            wr_q       <= 1'b0;
            idx_q      <= '0;
            strb_q     <= 4'd0;
            rdbuf_q    <= 32'd0;
`ifdef AHB_SLV_ERR_CNT_EN
            err_cnt_q  <= 8'd0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DATA, ST_ERR2: begin
                    if (accept_s) begin
                        if (illegal_s) begin
                            state_q  <= ST_ERR1;
                            hready_q <= 1'b0;
                            hresp_q  <= 1'b1;
`ifdef AHB_SLV_ERR_CNT_EN
                            if (err_cnt_q != 8'd255) begin
                                err_cnt_q <= err_cnt_q + 8'd1;
                            end
`endif
                        end else begin
                            idx_q   <= idx_s;
                            strb_q  <= strb_s;
                            wr_q    <= hwrite;
                            rdbuf_q <= rd_fetch_s;
                            hresp_q <= 1'b0;
                            if (WAIT_STATES > 0) begin
                                state_q    <= ST_WAIT;
                                hready_q   <= 1'b0;
                                wait_cnt_q <= WAIT_INIT;
                            end else begin
                                state_q  <= ST_DATA;
                                hready_q <= 1'b1;
                                if (!hwrite) begin
                                    hrdata_q <= rd_fetch_s;
                                end
                            end
                        end
                    end else begin
                        state_q  <= ST_IDLE;
                        hready_q <= 1'b1;
                        hresp_q  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    hresp_q <= 1'b0;
                    if (wait_cnt_q == 3'd0) begin
                        state_q  <= ST_DATA;
                        hready_q <= 1'b1;
                        if (!wr_q) begin
                            hrdata_q <= rdbuf_q;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 3'd1;
                        hready_q   <= 1'b0;
                    end
                end
                ST_ERR1: begin
                    state_q  <= ST_ERR2;
                    hready_q <= 1'b1;
                    hresp_q  <= 1'b1;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    hready_q <= 1'b1;
                    hresp_q  <= 1'b0;
                end
            endcase
        end
    end

    assign hrdata = hrdata_q;
    assign hready = hready_q;
    assign hresp  = hresp_q;
`ifdef AHB_SLV_ERR_CNT_EN
    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: three instances (W=0, W=3, W=2) share the
// bus; each is addressed through its own hsel line.
module tb_ahb_slave_mem;

    logic        clk = 1'b0;
    logic        hreset;
    logic [1:0]  hsel0, hsel3, hsel2;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic [31:0] rd0, rd3, rd2;
    logic        rdy0, rdy3, rdy2;
    logic        rsp0, rsp3, rsp2;
`ifdef AHB_SLV_ERR_CNT_EN
    logic [7:0]  ec0, ec3, ec2;
`endif

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    ahb_slave_mem #(.DEPTH(256), .WAIT_STATES(0), .SEL_ID(2'd1)) u0 (
        .clk(clk), .hreset(hreset), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
        .hrdata(rd0), .hready(rdy0), .hresp(rsp0)
`ifdef AHB_SLV_ERR_CNT_EN
        , .err_count(ec0)
`endif
    );

    ahb_slave_mem #(.DEPTH(256), .WAIT_STATES(3), .SEL_ID(2'd1)) u3 (
        .clk(clk), .hreset(hreset), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
        .hrdata(rd3), .hready(rdy3), .hresp(rsp3)
`ifdef AHB_SLV_ERR_CNT_EN
        , .err_count(ec3)
`endif
    );

    ahb_slave_mem #(.DEPTH(256), .WAIT_STATES(2), .SEL_ID(2'd1)) u2 (
        .clk(clk), .hreset(hreset), .hsel(hsel2), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
        .hrdata(rd2), .hready(rdy2), .hresp(rsp2)
`ifdef AHB_SLV_ERR_CNT_EN
        , .err_count(ec2)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_ph(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                           input logic [31:0] a);
        htrans = tr;
        hwrite = wr;
        hsize  = sz;
        haddr  = a;
    endtask

    task automatic idle();
        htrans = 2'd0;
        hwrite = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        hreset = 1'b1;
        hsel0  = 2'd0;
        hsel3  = 2'd0;
        hsel2  = 2'd0;
        haddr  = 32'd0;
        htrans = 2'd0;
        hwrite = 1'b0;
        hsize  = 3'd2;
        hburst = 3'd0;
        hwdata = 32'd0;
        step();
        step();
        chk("rst_hready0", {31'd0, rdy0}, 32'd1);
        chk("rst_hresp0",  {31'd0, rsp0}, 32'd0);
        chk("rst_hrdata0", rd0, 32'd0);
        chk("rst_hready3", {31'd0, rdy3}, 32'd1);
        chk("rst_hrdata3", rd3, 32'd0);
        hreset = 1'b0;

        // W=0: word write then back-to-back read through forwarding
        hsel0 = 2'd1;
        addr_ph(2'd2, 1'b1, 3'd2, 32'h10);
        step();
        chk("wr_data_hready", {31'd0, rdy0}, 32'd1);
        hwdata = 32'hDEADBEEF;
        addr_ph(2'd2, 1'b0, 3'd2, 32'h10);
        step();
        chk("raw_fwd_data",   rd0, 32'hDEADBEEF);
        chk("raw_fwd_hready", {31'd0, rdy0}, 32'd1);
        chk("raw_fwd_hresp",  {31'd0, rsp0}, 32'd0);
        idle();
        step();

        // Byte / half lanes, final read forwards the half write merged with memory
        addr_ph(2'd2, 1'b1, 3'd2, 32'h0);
        step();
        hwdata = 32'h11223344;
        addr_ph(2'd2, 1'b1, 3'd0, 32'h2);
        step();
        hwdata = 32'h00AA0000;
        addr_ph(2'd2, 1'b1, 3'd1, 32'h0);
        step();
        hwdata = 32'h0000BBCC;
        addr_ph(2'd2, 1'b0, 3'd2, 32'h0);
        step();
        chk("lanes_fwd", rd0, 32'h11AABBCC);
        idle();
        step();
        addr_ph(2'd2, 1'b0, 3'd2, 32'h10);
        step();
        chk("mem_word_10", rd0, 32'hDEADBEEF);
        addr_ph(2'd2, 1'b0, 3'd2, 32'h0);
        step();
        chk("mem_word_0", rd0, 32'h11AABBCC);
        addr_ph(2'd2, 1'b0, 3'd0, 32'h3);
        step();
        chk("byte_read_full_word", rd0, 32'h11AABBCC);
        addr_ph(2'd2, 1'b1, 3'd2, 32'h4);
        step();
        hwdata = 32'h12345678;
        idle();
        step();

        // Misaligned word read -> ERR1 then ERR2
        addr_ph(2'd2, 1'b0, 3'd2, 32'h2);
        step();
        chk("mis_err1_hready", {31'd0, rdy0}, 32'd0);
        chk("mis_err1_hresp",  {31'd0, rsp0}, 32'd1);
        idle();
        step();
        chk("mis_err2_hready", {31'd0, rdy0}, 32'd1);
        chk("mis_err2_hresp",  {31'd0, rsp0}, 32'd1);
        chk("mis_hrdata_hold", rd0, 32'h11AABBCC);
        step();
        chk("mis_after_hresp", {31'd0, rsp0}, 32'd0);

        // Out-of-range word write at 4*DEPTH (would alias word 0 if index wrapped)
        addr_ph(2'd2, 1'b1, 3'd2, 32'h400);
        step();
        chk("oor_err1_hready", {31'd0, rdy0}, 32'd0);
        chk("oor_err1_hresp",  {31'd0, rsp0}, 32'd1);
        hwdata = 32'hFFFFFFFF;
        idle();
        step();
        chk("oor_err2_hready", {31'd0, rdy0}, 32'd1);
        chk("oor_err2_hresp",  {31'd0, rsp0}, 32'd1);
        step();
        addr_ph(2'd2, 1'b0, 3'd2, 32'h0);
        step();
        chk("err_mem_unchanged", rd0, 32'h11AABBCC);
        idle();
        step();

        // Unselected write and BUSY write leave word 4 intact
        hsel0 = 2'd2;
        addr_ph(2'd2, 1'b1, 3'd2, 32'h4);
        step();
        chk("unsel_hready", {31'd0, rdy0}, 32'd1);
        chk("unsel_hresp",  {31'd0, rsp0}, 32'd0);
        hwdata = 32'h00000055;
        idle();
        step();
        chk("unsel_hready2", {31'd0, rdy0}, 32'd1);
        hsel0 = 2'd1;
        addr_ph(2'd1, 1'b1, 3'd2, 32'h4);
        step();
        chk("busy_hready", {31'd0, rdy0}, 32'd1);
        chk("busy_hresp",  {31'd0, rsp0}, 32'd0);
        hwdata = 32'h00000099;
        idle();
        step();
        addr_ph(2'd2, 1'b0, 3'd2, 32'h4);
        step();
        chk("unsel_busy_mem", rd0, 32'h12345678);
        idle();
        step();
        hsel0 = 2'd0;
`ifdef AHB_SLV_ERR_CNT_EN
        chk("err_count", {24'd0, ec0}, 32'd2);
`endif

        // W=3: write then read; hready low for three cycles after accept
        hsel3 = 2'd1;
        addr_ph(2'd2, 1'b1, 3'd2, 32'h20);
        step();
        chk("w3_wr_wait", {31'd0, rdy3}, 32'd0);
        idle();
        hwdata = 32'hCAFEF00D;
        step();
        step();
        step();
        chk("w3_wr_data", {31'd0, rdy3}, 32'd1);
        step();
        addr_ph(2'd2, 1'b0, 3'd2, 32'h20);
        step();
        chk("w3_rd_n1", {31'd0, rdy3}, 32'd0);
        idle();
        step();
        chk("w3_rd_n2", {31'd0, rdy3}, 32'd0);
        step();
        chk("w3_rd_n3", {31'd0, rdy3}, 32'd0);
        step();
        chk("w3_rd_n4_hready", {31'd0, rdy3}, 32'd1);
        chk("w3_rd_n4_hresp",  {31'd0, rsp3}, 32'd0);
        chk("w3_rd_n4_data",   rd3, 32'hCAFEF00D);
        step();
        hsel3 = 2'd0;

        // W=2: reset during the wait of a write drops it
        hsel2 = 2'd1;
        addr_ph(2'd2, 1'b1, 3'd2, 32'h8);
        step();
        idle();
        hwdata = 32'h0BADF00D;
        step();
        step();
        step();
        addr_ph(2'd2, 1'b0, 3'd2, 32'h8);
        step();
        idle();
        step();
        step();
        chk("w2_rd_data", rd2, 32'h0BADF00D);
        step();
        addr_ph(2'd2, 1'b1, 3'd2, 32'h8);
        step();
        chk("w2_wr_wait", {31'd0, rdy2}, 32'd0);
        idle();
        hwdata = 32'hFFFFFFFF;
        hreset = 1'b1;
        step();
        chk("rst_mid_hready", {31'd0, rdy2}, 32'd1);
        chk("rst_mid_hresp",  {31'd0, rsp2}, 32'd0);
        chk("rst_mid_hrdata", rd2, 32'd0);
        hreset = 1'b0;
        step();
        step();
        addr_ph(2'd2, 1'b0, 3'd2, 32'h8);
        step();
        idle();
        step();
        step();
        chk("rst_no_commit", rd2, 32'h0BADF00D);
        step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
AHB-Lite style memory slave sitting directly downstream of ahb_master. It consumes the master's address/control/write-data bus and returns hrdata/hready/hresp. It is backed by a word-addressed register array, with a programmable number of wait states and pipelined address/data phases. It returns the two-cycle ERROR response for illegal accesses.

Parameters:
DEPTH, 256, number of 32-bit words; power of two, 4..4096.
WAIT_STATES, 0, hready-low cycles inserted per data phase, 0..7.
SEL_ID, 2'd1, hsel value that selects this slave.

Ports:
clk  input  1  clock, all logic on posedge.
hreset  input  1  synchronous active-high reset.
hsel  input  2  slave select; slave addressed when hsel==SEL_ID.
haddr  input  32  byte address (address phase).
htrans  input  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
hwrite  input  1  1=write, 0=read.
hsize  input  3  0 byte, 1 half, 2 word; >2 illegal.
hburst  input  3  burst type; informational only, no checking.
hwdata  input  32  write data (data phase).
hrdata  output  32  read data, registered.
hready  output  1  transfer done / slave ready, registered.
hresp  output  1  0 OKAY, 1 ERROR, registered.

Behaviour:
- Reset (hreset=1 at posedge): state IDLE, hready=1, hresp=0, hrdata=0. Any pending write is dropped. Memory array is not cleared.
- Accept a transfer at posedge when hready=1, hsel==SEL_ID and htrans[1]=1. Register addr, hwrite, hsize at that edge.
- IDLE/BUSY transfers, or an unselected slave: no access, OKAY, zero wait.
- Illegal access, checked at accept:
  - hsize>2.
  - Misaligned: half with haddr[0]=1; word with haddr[1:0]!=0.
  - Word index haddr[31:2] >= DEPTH.
- States: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: on legal accept -> WAIT if WAIT_STATES>0, else DATA. On illegal accept -> ERR1.
  - WAIT: hready=0, hresp=0; counts WAIT_STATES cycles, then -> DATA.
  - DATA: hready=1, hresp=0 for exactly one cycle.
    - Read: hrdata valid in this cycle.
    - Write: hwdata sampled at the closing edge and written to the selected byte lanes.
    - A new accept in this cycle is pipelined (back-to-back); otherwise -> IDLE.
  - ERR1: hready=0, hresp=1 (one cycle) -> ERR2.
  - ERR2: hready=1, hresp=1 (one cycle); no memory access. Accept allowed here, as in DATA.
- Latency with WAIT_STATES=W: data phase lasts W+1 cycles after the accept edge. Legal back-to-back throughput is 1 per W+1 cycles.
- Byte lanes are little-endian.
  - Byte: lane haddr[1:0].
  - Half: lanes {haddr[1],0} and {haddr[1],1}.
  - Reads return the full word; unselected lanes carry memory contents.
- Read data is fetched at the accept edge.
- Read-after-write hazard: a read accepted in the closing edge of a write to the same word gets that write's bytes forwarded, merged per lane.
- hrdata holds its last value outside read DATA cycles. It is not updated on writes or errors.
- Errored and unselected transfers never modify memory.
- Reset mid-transfer: takes effect at that edge; the in-flight write is not committed.

Optional Feature:
AHB_SLV_ERR_CNT_EN
- Defined: adds output err_count (8 bits), reset to 0. Increments on each ERR1 entry and saturates at 255.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Word write then read, W=0: write 0xDEADBEEF to 0x10, then read 0x10 back-to-back. Read DATA cycle hrdata=0xDEADBEEF via forwarding, hready=1, hresp=0.
- Byte/half lanes: word 0x0 set to 0x11223344. Byte write 0xAA to 0x2 (hwdata=0x00AA0000), then half write 0xBBCC to 0x0. Read 0x0 returns 0x11AABBCC.
- Wait states, W=3: read accepted at edge N gives hready=0 for cycles N+1..N+3 and hready=1 with data at N+4.
- Errors:
  - Word read at 0x2 (misaligned): ERR1 hready=0/hresp=1, then ERR2 hready=1/hresp=1.
  - Address 4*DEPTH: same ERROR sequence.
  - Memory unchanged after both.
- Unselected and idle: hsel!=SEL_ID with write 0x55 to 0x4 leaves memory unchanged and hready stays 1. htrans=BUSY gives OKAY with no access.
- Reset mid-write, W=2: assert hreset during WAIT. Then hready=1, hresp=0, hrdata=0, and the target word keeps its old value.
